// File: rtl/mem_access_unit.sv
// Load/store unit: sequences one request at a time onto a synchronous data RAM and aligns results.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of silently aligning them.
module mem_access_unit #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        accept;
  logic        mis_q, mis_d;
  logic        req_mis;
  logic [31:0] ld_shift, ld_data;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    req_mis = 1'b0;
    if (req_size == 2'b01)      req_mis = req_addr[0];
    else if (req_size[1])       req_mis = (req_addr[1:0] != 2'b00);
  end
  assign misalign = (state_q == RESP) && mis_q;
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    stall   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall  = 1'b1;
          accept = 1'b1;
          mis_d  = req_mis;
          if (req_mis) begin
            // Trapped access skips the RAM and reports a zero result.
            state_d = RESP;
            rdata_d = 32'h0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'h0;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == WLAST) begin
          state_d = RESP;
          rdata_d = ld_data;
        end else begin
          cnt_d = cnt_q + 4'h1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Load alignment: move the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00: ld_data = uns_q ? {24'h0, ld_shift[7:0]}
                             : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01: begin
        ld_data = addr_q[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
        if (!uns_q) ld_data[31:16] = {16{ld_data[15]}};
      end
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        wdata_raw = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_raw    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_raw = {2{wdata_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = wdata_q;
      end
    endcase
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_be    = mem_en ? be_raw : 4'b0000;
  assign mem_addr  = addr_q[31:2];
  assign mem_wdata = wdata_raw;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: unit "a" has WAIT_CYCLES=1, unit "b" WAIT_CYCLES=3; both share the request stimulus.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic        a_stall, a_rsp_valid, a_mem_en, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic [29:0] a_mem_addr;
  logic        b_stall, b_rsp_valid, b_mem_en, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [29:0] b_mem_addr;
`ifdef MISALIGN_TRAP_EN
  logic        a_mis, b_mis;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(a_stall), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign(a_mis)
`endif
  );

  mem_access_unit #(.WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(b_stall), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign(b_mis)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents a request for one cycle (cycle T); returns 1ns into cycle T+1.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    #1 check("stall_T", {31'b0, a_stall}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Load on unit a: result is visible in cycle T+3.
  task automatic load_a(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, sz, uns, addr, 32'h0);
    tick(); tick(); #1;
    check({tag, "_vld"}, {31'b0, a_rsp_valid}, 32'd1);
    check(tag, a_rsp_rdata, exp);
    idle(4);
  endtask

  logic exp_stall [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic exp_en    [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic exp_rv    [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst_mem_en", {31'b0, a_mem_en}, 32'd0);
    check("rst_mem_be", {28'b0, a_mem_be}, 32'h0);
    check("rst_stall", {31'b0, a_stall}, 32'd0);

    // Word load, one wait cycle: full cycle-by-cycle timing.
    mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    check("lw_mem_en", {31'b0, a_mem_en}, 32'd1);
    check("lw_mem_addr", {2'b0, a_mem_addr}, 32'h40);
    check("lw_mem_we", {31'b0, a_mem_we}, 32'd0);
    check("lw_rv_T1", {31'b0, a_rsp_valid}, 32'd0);
    tick(); #1;
    check("lw_rv_T2", {31'b0, a_rsp_valid}, 32'd0);
    check("lw_en_T2", {31'b0, a_mem_en}, 32'd0);
    check("lw_stall_T2", {31'b0, a_stall}, 32'd1);
    tick(); #1;
    check("lw_rv_T3", {31'b0, a_rsp_valid}, 32'd1);
    check("lw_rdata", a_rsp_rdata, 32'hDEADBEEF);
    check("lw_stall_T3", {31'b0, a_stall}, 32'd0);
    tick(); #1;
    check("lw_rv_T4", {31'b0, a_rsp_valid}, 32'd0);
    check("lw_hold", a_rsp_rdata, 32'hDEADBEEF);
    idle(3);

    mem_rdata = 32'h80112233;
    load_a("lb_s",  2'b00, 1'b0, 32'h103, 32'hFFFFFF80);
    load_a("lbu",   2'b00, 1'b1, 32'h103, 32'h00000080);
    load_a("lb_l1", 2'b00, 1'b0, 32'h101, 32'h00000022);
    load_a("lh_s",  2'b01, 1'b0, 32'h102, 32'hFFFF8011);
    load_a("lhu",   2'b01, 1'b1, 32'h100, 32'h00002233);

    // Stores: lane steering and two-cycle completion, rdata untouched.
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
    #1;
    check("sh_be", {28'b0, a_mem_be}, 32'hC);
    check("sh_wdata", a_mem_wdata, 32'hABCDABCD);
    check("sh_we", {31'b0, a_mem_we}, 32'd1);
    check("sh_addr", {2'b0, a_mem_addr}, 32'h80);
    tick(); #1;
    check("sh_rv_T2", {31'b0, a_rsp_valid}, 32'd1);
    check("sh_rdata_keep", a_rsp_rdata, 32'h00002233);
    tick(); #1;
    check("sh_be_idle", {28'b0, a_mem_be}, 32'h0);
    check("sh_we_idle", {31'b0, a_mem_we}, 32'd0);
    idle(4);

    issue(1'b1, 2'b00, 1'b0, 32'h201, 32'h1234565A);
    #1;
    check("sb_be", {28'b0, a_mem_be}, 32'h2);
    check("sb_wdata", a_mem_wdata, 32'h5A5A5A5A);
    idle(5);

    issue(1'b1, 2'b11, 1'b0, 32'h204, 32'h11223344);
    #1;
    check("sw_be", {28'b0, a_mem_be}, 32'hF);
    check("sw_wdata", a_mem_wdata, 32'h11223344);
    check("sw_addr", {2'b0, a_mem_addr}, 32'h81);
    idle(5);

`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    #1;
    check("mis_mem_en", {31'b0, a_mem_en}, 32'd0);
    check("mis_rv", {31'b0, a_rsp_valid}, 32'd1);
    check("mis_flag", {31'b0, a_mis}, 32'd1);
    check("mis_rdata", a_rsp_rdata, 32'h0);
    tick(); #1;
    check("mis_flag_clr", {31'b0, a_mis}, 32'd0);
    idle(4);
`else
    mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    #1;
    check("unal_mem_en", {31'b0, a_mem_en}, 32'd1);
    check("unal_addr", {2'b0, a_mem_addr}, 32'h40);
    tick(); tick(); #1;
    check("unal_rdata", a_rsp_rdata, 32'hCAFEF00D);
    idle(4);
`endif

    // Held request on the three-wait unit: stall window, RESP gap, re-accept in IDLE.
    mem_rdata = 32'h12345678;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("hold_stall_%0d", k), {31'b0, b_stall}, {31'b0, exp_stall[k]});
      check($sformatf("hold_en_%0d", k), {31'b0, b_mem_en}, {31'b0, exp_en[k]});
      check($sformatf("hold_rv_%0d", k), {31'b0, b_rsp_valid}, {31'b0, exp_rv[k]});
      tick();
    end
    req_valid = 1'b0;
    idle(8);
    check("hold_rdata", b_rsp_rdata, 32'h12345678);

    // Reset during WAIT aborts the load silently.
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_rv", {31'b0, b_rsp_valid}, 32'd0);
    check("abort_en", {31'b0, b_mem_en}, 32'd0);
    check("abort_be", {28'b0, b_mem_be}, 32'h0);
    check("abort_we", {31'b0, b_mem_we}, 32'd0);
    check("abort_rdata", b_rsp_rdata, 32'h0);
    check("abort_stall", {31'b0, b_stall}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check($sformatf("abort_rv_%0d", k), {31'b0, b_rsp_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1, meaning data-RAM read latency in cycles after the mem_en cycle (legal range 1..15).
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port req_valid  input  1  load/store request from the execute stage.
REQ-005 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL provide port req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 SHALL provide port req_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-008 SHALL provide ports req_addr  input  32  byte address; req_wdata  input  32  store data.
REQ-009 SHALL provide port stall  output  1  pipeline hold request to upstream stages.
REQ-010 SHALL provide ports rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  32  aligned load result, feeding the 32-bit memory/write-back pipeline register.
REQ-011 SHALL provide RAM ports mem_en  output  1; mem_we  output  1; mem_be  output  4; mem_addr  output  30  word address (req_addr[31:2]); mem_wdata  output  32; mem_rdata  input  32.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-013 SHALL, in IDLE with req_valid=1 at cycle T, latch all req_* fields and enter ACCESS at T+1; req_* inputs are ignored in every other state.
REQ-014 SHALL drive mem_en=1 only in ACCESS (exactly one cycle per request), with mem_we, mem_be, mem_addr, mem_wdata valid in that cycle; mem_we=0, mem_be=0000 outside ACCESS.
REQ-015 SHALL, for a load, go ACCESS -> WAIT, stay WAIT_CYCLES cycles, capture mem_rdata on the last WAIT cycle, then enter RESP (rsp_valid at T+2+WAIT_CYCLES).
REQ-016 SHALL, for a store, go ACCESS -> RESP directly (rsp_valid at T+2), leaving rsp_rdata unchanged.
REQ-017 SHALL return RESP -> IDLE unconditionally; a req_valid in the RESP cycle is not accepted, and a new request is accepted earliest in the following IDLE cycle.
REQ-018 SHALL assert stall combinationally in IDLE when req_valid=1, and in ACCESS and WAIT; stall=0 in RESP and in IDLE without req_valid.
REQ-019 SHALL generate store lanes little-endian: byte -> be=0001<<addr[1:0], wdata[7:0] replicated to all 4 lanes; half -> be=0011<<(2*addr[1]), wdata[15:0] replicated; word -> be=1111, wdata unchanged.
REQ-020 SHALL align loads: byte lane addr[1:0], halfword lane addr[1], shifted to bit 0 and extended per req_unsigned; word unchanged.
REQ-021 SHALL, without the configuration macro, ignore addr[0] for halfwords and addr[1:0] for words.
REQ-022 SHALL hold rsp_rdata stable from RESP until the next load's RESP.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, enter IDLE, clear wait counter and latched request, and set rsp_rdata=0, rsp_valid=0, mem_en=0, mem_we=0, mem_be=0000.
REQ-024 SHALL abort an in-flight request on reset mid-operation without a rsp_valid pulse; rst has priority over req_valid in the same cycle.

Configuration
REQ-025 SHALL, with macro MISALIGN_TRAP_EN defined, add port misalign  output  1, and treat half with addr[0]=1 or word with addr[1:0]!=00 as misaligned: ACCESS skipped (no mem_en), IDLE -> RESP at T+1, rsp_valid=1 and misalign=1 for that cycle, rsp_rdata=0; misalign=0 otherwise and after reset.
REQ-026 SHALL, without MISALIGN_TRAP_EN, omit the misalign port and behave per REQ-021.

Verification
REQ-027 SHALL cover: WAIT_CYCLES=1, load word addr 0x100, mem_rdata=0xDEADBEEF -> mem_en at T+1, mem_addr=0x40, rsp_valid at T+3, rsp_rdata=0xDEADBEEF.
REQ-028 SHALL cover: signed byte load addr 0x103, mem_rdata=0x80112233 -> rsp_rdata=0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
REQ-029 SHALL cover: store half addr 0x202, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, rsp_valid at T+2.
REQ-030 SHALL cover: WAIT_CYCLES=3 load, rst asserted at T+2 -> IDLE at T+3, no rsp_valid, all outputs zero.
REQ-031 SHALL cover: req_valid held high continuously -> stall high T..T+1+WAIT_CYCLES, low in RESP, second request accepted in the IDLE cycle after RESP.
REQ-032 SHALL cover, with MISALIGN_TRAP_EN: load word addr 0x101 -> no mem_en, rsp_valid and misalign at T+1, rsp_rdata=0.
